// File: rtl/id_ex_pkg.sv
// Shared types for the decode->execute pipeline register: control/data bundles and helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package id_ex_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ALU_CTRL_WIDTH = 4;

    typedef struct packed {
        logic                      reg_write;
        logic [1:0]                result_src;
        logic                      mem_write;
        logic                      branch;
        logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
        logic                      alu_src;
        logic [2:0]                imm_src;
        logic                      jalr;
        logic [2:0]                funct3;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     rd1;
        logic [DATA_WIDTH-1:0]     rd2;
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     imm_ext;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic [DATA_WIDTH-1:0]     addr_sel;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } id_ex_data_t;

    localparam id_ex_ctrl_t ID_EX_CTRL_BUBBLE = '0;

    // Strip every field that could change architectural state or redirect the PC.
    function automatic id_ex_ctrl_t gate_bubble(input id_ex_ctrl_t c);
        id_ex_ctrl_t g;
        g           = c;
        g.reg_write = 1'b0;
        g.mem_write = 1'b0;
        g.branch    = 1'b0;
        g.jalr      = 1'b0;
        return g;
    endfunction

    // x0 is hardwired to zero, so a write to it is dropped at capture time.
    function automatic id_ex_ctrl_t gate_rd0(input id_ex_ctrl_t c,
                                             input logic [REG_ADDR_WIDTH-1:0] rd);
        id_ex_ctrl_t g;
        g           = c;
        g.reg_write = c.reg_write & (rd != '0);
        return g;
    endfunction

endpackage

// File: rtl/id_ex_skid_buf.sv
// One-entry payload+valid holding register that catches an instruction while the main stage stalls.
// Latency: 1 cycle from i_load to o_valid.
// Backpressure: none internally; the parent only loads it while it is empty.
module id_ex_skid_buf
    import id_ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_clear,
    input  id_ex_ctrl_t i_ctrl,
    input  id_ex_data_t i_data,
    output logic        o_valid,
    output id_ex_ctrl_t o_ctrl,
    output id_ex_data_t o_data
);

    logic        r_valid;
    id_ex_ctrl_t r_ctrl;
    id_ex_data_t r_data;

    // Clear (drain or flush) beats load; payload is only written on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// Decode->execute pipeline register with valid/ready handshake, flush-to-bubble and x0 write gating.
// Latency: 1 cycle; optional skid entry (ID_EX_SKID_EN) keeps ready_o registered at 1 instr/cycle.
// Backpressure: stalls hold the main register; without skid ready_o = ~valid | ready_i.
module id_ex_pipe_stage
    import id_ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        flush_i,
    input  id_ex_ctrl_t ctrl_i,
    input  id_ex_data_t data_i,
    output logic        valid_o,
    input  logic        ready_i,
    output id_ex_ctrl_t ctrl_o,
    output id_ex_data_t data_o
);

    logic        r_valid;
    id_ex_ctrl_t r_ctrl;
    id_ex_data_t r_data;

    logic        w_accept;
    logic        w_issue;
    logic        w_load_main;
    id_ex_ctrl_t w_ctrl_in;
    id_ex_ctrl_t w_next_ctrl;
    id_ex_data_t w_next_data;

    assign w_accept  = valid_i & ready_o;
    assign w_issue   = r_valid & ready_i;
    assign w_ctrl_in = gate_rd0(ctrl_i, data_i.rd);

`ifdef ID_EX_SKID_EN
    logic        w_skid_vld;
    logic        w_skid_load;
    logic        w_skid_clear;
    id_ex_ctrl_t w_skid_ctrl;
    id_ex_data_t w_skid_data;

    // Catch the input only when main is full and cannot move this cycle.
    assign w_skid_load  = w_accept & r_valid & ~ready_i & ~flush_i;
    // Empty on flush, or when its entry moves into main on an issue.
    assign w_skid_clear = flush_i | (w_skid_vld & w_issue);

    id_ex_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (w_ctrl_in),
        .i_data  (data_i),
        .o_valid (w_skid_vld),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    // Ready comes straight off the skid flop: no ready_i->ready_o path.
    assign ready_o = ~w_skid_vld;

    // Older skid entry goes first; input can't be accepted while skid is full.
    always_comb begin
        w_load_main = ~flush_i &
                      ((w_skid_vld & w_issue) | (w_accept & (~r_valid | ready_i)));
        w_next_ctrl = w_skid_vld ? w_skid_ctrl : w_ctrl_in;
        w_next_data = w_skid_vld ? w_skid_data : data_i;
    end
`else
    assign ready_o = ~r_valid | ready_i;

    // Accept already implies main is empty or draining this cycle.
    always_comb begin
        w_load_main = ~flush_i & w_accept;
        w_next_ctrl = w_ctrl_in;
        w_next_data = data_i;
    end
`endif

    // Main register: flush first, then load, then drain on a bare issue; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_load_main) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_next_ctrl;
            r_data  <= w_next_data;
        end else if (w_issue) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign ctrl_o  = r_valid ? r_ctrl : gate_bubble(r_ctrl);
    assign data_o  = r_data;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Scoreboard bench for id_ex_pipe_stage: directed scenarios followed by randomized traffic.
// Expected items are queued at accept time; a monitor pops and compares on each issue.
// Occupancy of the model queue predicts valid_o and ready_o.
module tb_id_ex_pipe_stage;
    import id_ex_pkg::*;

`ifdef ID_EX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    id_ex_ctrl_t ctrl_i;
    id_ex_data_t data_i;
    logic        valid_o;
    logic        ready_i;
    id_ex_ctrl_t ctrl_o;
    id_ex_data_t data_o;

    typedef struct {
        id_ex_ctrl_t c;
        id_ex_data_t d;
    } item_t;

    item_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    bit    mon_en   = 1'b0;
    bit    seen_20  = 1'b0;

    always #5 clk = ~clk;

    id_ex_pipe_stage dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .flush_i (flush_i),
        .ctrl_i  (ctrl_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .ctrl_o  (ctrl_o),
        .data_o  (data_o)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: at each falling edge compare DUT outputs with the head of the model queue.
    initial begin : monitor
        bit exp_rdy;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_rdy = SKID ? (sb.size() < 2) : ((sb.size() == 0) || ready_i);
                chk("valid_o", valid_o, sb.size() != 0);
                chk("ready_o", ready_o, exp_rdy);
                if (valid_o && sb.size() != 0) begin
                    chk("ctrl_o", ctrl_o, sb[0].c);
                    chk("data_o", data_o, sb[0].d);
                    if (ready_i) begin
                        if (data_o.pc == 32'h20) seen_20 = 1'b1;
                        void'(sb.pop_front());
                    end
                end
                if (!valid_o)
                    chk("bubble_gate", {ctrl_o.reg_write, ctrl_o.mem_write, ctrl_o.branch, ctrl_o.jalr}, 4'b0);
            end
        end
    end

    // One clock of stimulus; the expected item is queued if the handshake completes.
    task automatic step(input bit v, input bit f, input bit r,
                        input logic [31:0] pc, input logic [4:0] rd, input bit rw);
        item_t       it;
        logic [31:0] rnd;
        @(posedge clk);
        #1;
        valid_i = v;
        flush_i = f;
        ready_i = r;
        rnd     = $urandom;
        ctrl_i  = rnd[$bits(id_ex_ctrl_t)-1:0];
        ctrl_i.reg_write = rw;
        data_i.rd1      = $urandom;
        data_i.rd2      = $urandom;
        data_i.pc       = pc;
        data_i.imm_ext  = $urandom;
        data_i.pc_plus4 = pc + 32'd4;
        data_i.addr_sel = $urandom;
        data_i.rd       = rd;
        @(negedge clk);
        #2;
        if (f) begin
            sb.delete();
        end else if (v && ready_o) begin
            it.c = ctrl_i;
            if (rd == 5'd0) it.c.reg_write = 1'b0;
            it.d = data_i;
            sb.push_back(it);
        end
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, r, 32'h0, 5'd1, 1'b0);
    endtask

    initial begin : driver
        logic [31:0] pc;
        logic [4:0]  rd;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        ctrl_i  = '0;
        data_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", valid_o, 1'b0);
        chk("reset_ctrl", ctrl_o, '0);
        chk("reset_data", data_o, '0);
        rst_n = 1'b1;
        #1;
        chk("reset_ready", ready_o, 1'b1);
        mon_en = 1'b1;

        // Back-to-back flow
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 32'(i * 4), 5'd1, 1'b1);
        idle(2, 1'b1);

        // Stall with 0x10 held; skid build takes 0x14 once
        step(1'b1, 1'b0, 1'b1, 32'h10, 5'd2, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h14, 5'd2, 1'b1);
        idle(3, 1'b1);

        // Flush with main (and skid, if present) occupied
        step(1'b1, 1'b0, 1'b0, 32'h1C, 5'd3, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h24, 5'd3, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h20, 5'd3, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h0, 5'd1, 1'b0);
        chk("flush_valid", valid_o, 1'b0);
        chk("flush_reg_write", ctrl_o.reg_write, 1'b0);
        idle(2, 1'b1);
        chk("flush_no_0x20", seen_20, 1'b0);

        // rd==0 write suppression
        step(1'b1, 1'b0, 1'b1, 32'h30, 5'd0, 1'b1);
        idle(2, 1'b1);

        // Flush during stall
        step(1'b1, 1'b0, 1'b1, 32'h40, 5'd5, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h44, 5'd6, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h48, 5'd7, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 5'd1, 1'b0);
        chk("flush_stall_valid", valid_o, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 5'd1, 1'b0);
        chk("flush_stall_ready", ready_o, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            pc = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0, pc, rd, 1'($urandom));
        end
        idle(4, 1'b1);
        chk("drain_empty", sb.size(), 0);

        // Asynchronous reset mid-stream while an instruction is held
        step(1'b1, 1'b0, 1'b0, 32'h50, 5'd4, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 5'd1, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_reset_valid", valid_o, 1'b1);
        mon_en  = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("async_reset_valid", valid_o, 1'b0);
        chk("async_reset_ctrl", ctrl_o, '0);
        chk("async_reset_data", data_o, '0);
        sb.delete();
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready", ready_o, 1'b1);
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 32'h60 + 32'(i * 4), 5'd9, 1'b1);
        idle(3, 1'b1);
        chk("final_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
